tv80_alu16_seq: RTL and testbench
=================================

TV80_ALU16_SEQ -- requirements
Module: tv80_alu16_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, on ports clk and reset.
REQ-002 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  request a 16-bit operation; sampled only in IDLE.
- op  in  2  operation: 00 ADD16, 01 ADC16, 10 SBC16, 11 SUB16.
- opa  in  16  first operand.
- opb  in  16  second operand.
- f_in  in  8  flag register in (C=bit0, N=1, P=2, X=3, H=4, Y=5, Z=6, S=7).
- busy  out  1  high while the state is not IDLE.
- done  out  1  one-cycle pulse; result and f_out are valid.
- result  out  16  16-bit result, held until the next accepted start.
- f_out  out  8  resulting flags, held until the next accepted start.
- alu_op  out  4  ALU operation code.
- alu_bus_a  out  8  ALU operand A.
- alu_bus_b  out  8  ALU operand B.
- alu_f_in  out  8  ALU flag input.
- alu_arith16  out  1  ALU 16-bit arithmetic flag (preserve S, Z, P).
- alu_z16  out  1  ALU 16-bit zero-chaining flag.
- alu_q  in  8  ALU result (combinational).
- alu_f  in  8  ALU flags out (combinational).

Function
REQ-003 SHALL implement a state machine with four states: IDLE, LO, HI, DONE.
REQ-004 SHALL, in IDLE with start=1, capture op, opa, opb and f_in, and move to LO on that edge; start SHALL be ignored in every other state.
REQ-005 SHALL move LO->HI->DONE->IDLE unconditionally, one edge each.
- start sampled at edge 0 gives done=1 during the cycle after edge 2.
- Throughput: one operation per 4 cycles.
REQ-006 SHALL, in LO, drive the ALU as follows.
- alu_bus_a = opa[7:0]; alu_bus_b = opb[7:0]; alu_f_in = captured f_in.
- alu_op: ADD16 0000, ADC16 0001, SBC16 0011, SUB16 0010.
- alu_z16 = 0.
REQ-007 SHALL, at the end of LO, register alu_q into result[7:0] and alu_f into an internal low-flag register.
REQ-008 SHALL, in HI, drive the ALU as follows.
- alu_bus_a = opa[15:8]; alu_bus_b = opb[15:8]; alu_f_in = low-flag register.
- alu_op: ADD16 and ADC16 use 0001; SBC16 and SUB16 use 0011 (carry chains through the C flag).
REQ-009 SHALL, at the end of HI, register alu_q into result[15:8] and alu_f into f_out.
REQ-010 SHALL set alu_arith16 = 1 in LO and HI for ADD16 only (S, Z, P preserved from captured f_in), and 0 otherwise.
REQ-011 SHALL set alu_z16 = 1 in HI for ADC16, SBC16 and SUB16, so that final Z = (result == 0x0000).
REQ-012 SHALL drive alu_op = 1111 (flags pass through), buses 0x00, alu_f_in = 0x00 and alu_arith16 = alu_z16 = 0 in IDLE and DONE.
REQ-013 SHALL assert done only in DONE.
REQ-014 SHALL assert busy in LO, HI and DONE.
REQ-015 SHALL leave result and f_out unchanged in IDLE and DONE.
REQ-016 SHALL NOT let a change on opa, opb, f_in or op after acceptance affect an in-flight operation.
REQ-017 SHALL let the carry/borrow wrap out of bit 15 into C only; the result is modulo 2^16.

Reset
REQ-018 SHALL, while reset=1 (asynchronously), force the following, regardless of current state.
- state = IDLE; busy = 0; done = 0.
- result = 0x0000; f_out = 0x00; low-flag register = 0x00.
- ALU outputs = IDLE values.
REQ-019 SHALL NOT produce a done pulse for an operation interrupted by reset; the first start after reset deasserts is accepted normally.

Verification
REQ-020 SHALL pass these directed scenarios:
- ADD16: opa=0x7FFF, opb=0x0001, f_in=0x00 -> result=0x8000, f_out=0x10, done 3 edges after start.
- ADC16: opa=0xFFFF, opb=0x0000, f_in=0x01 -> result=0x0000, f_out=0x51.
- SBC16: opa=0x8000, opb=0x0001, f_in=0x00 -> result=0x7FFF, f_out=0x3E.
- Z chaining: ADC16 0x0100+0x0000, f_in=0x00 -> result=0x0100, Z=0; SUB16 0x1234-0x1234 -> result=0x0000, Z=1, C=0, N=1.
- Protocol: start held high for 8 cycles -> exactly 2 operations, done pulses 4 cycles apart; start in LO/HI/DONE is ignored.
- Reset in HI: reset pulse -> busy=0, result=0x0000, f_out=0x00 immediately, no done; the next start completes correctly.

Source files
------------

// File: rtl/tv80_alu16_seq.sv
// Sequences a 16-bit ADD/ADC/SBC/SUB through the external 8-bit TV80 ALU.
// The low byte is computed first and its flags carry into the high byte.
module tv80_alu16_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [7:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  f_out,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_bus_a,
  output logic [7:0]  alu_bus_b,
  output logic [7:0]  alu_f_in,
  output logic        alu_arith16,
  output logic        alu_z16,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_f
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SBC = 2'b10,
    OP_SUB = 2'b11
  } op16_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_e;

  state_e      state;
  op16_e       op_q;
  logic [15:0] opa_q;
  logic [15:0] opb_q;
  logic [7:0]  f_q;
  logic [7:0]  f_lo;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the operand capture regs are reset too, they are few.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 16'h0000;
      f_out  <= 8'h00;
      f_lo   <= 8'h00;
      op_q   <= OP_ADD;
      opa_q  <= 16'h0000;
      opb_q  <= 16'h0000;
      f_q    <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op16_e'(op);
            opa_q <= opa;
            opb_q <= opb;
            f_q   <= f_in;
            busy  <= 1'b1;
            state <= S_LO;
          end
        end
        S_LO: begin
          result[7:0] <= alu_q;
          f_lo        <= alu_f;
          state       <= S_HI;
        end
        S_HI: begin
          result[15:8] <= alu_q;
          f_out        <= alu_f;
          done         <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets its idle value first so no path leaves a latch.
  always_comb begin
    alu_op      = 4'b1111;
    alu_bus_a   = 8'h00;
    alu_bus_b   = 8'h00;
    alu_f_in    = 8'h00;
    alu_arith16 = 1'b0;
    alu_z16     = 1'b0;
    case (state)
      S_LO: begin
        alu_bus_a   = opa_q[7:0];
        alu_bus_b   = opb_q[7:0];
        alu_f_in    = f_q;
        alu_arith16 = (op_q == OP_ADD);
        case (op_q)
          OP_ADD:  alu_op = 4'b0000;
          OP_ADC:  alu_op = 4'b0001;
          OP_SBC:  alu_op = 4'b0011;
          default: alu_op = 4'b0010;
        endcase
      end
      S_HI: begin
        // High byte always chains the low-byte carry/borrow through C.
        alu_bus_a   = opa_q[15:8];
        alu_bus_b   = opb_q[15:8];
        alu_f_in    = f_lo;
        alu_arith16 = (op_q == OP_ADD);
        alu_z16     = (op_q != OP_ADD);
        alu_op      = (op_q == OP_ADD || op_q == OP_ADC) ? 4'b0001 : 4'b0011;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// Bench for tv80_alu16_seq: byte-ALU model on the ALU port, 16-bit arithmetic
// reference model, per-cycle compare plus directed literal scenarios.
module tb_tv80_alu16_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opa, opb;
  logic [7:0]  f_in;
  logic        busy, done;
  logic [15:0] result;
  logic [7:0]  f_out;
  logic [3:0]  alu_op;
  logic [7:0]  alu_bus_a, alu_bus_b, alu_f_in;
  logic        alu_arith16, alu_z16;
  logic [7:0]  alu_q, alu_f;

  int n_cmp = 0;
  int n_err = 0;

  tv80_alu16_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .f_in(f_in), .busy(busy), .done(done), .result(result), .f_out(f_out),
    .alu_op(alu_op), .alu_bus_a(alu_bus_a), .alu_bus_b(alu_bus_b),
    .alu_f_in(alu_f_in), .alu_arith16(alu_arith16), .alu_z16(alu_z16),
    .alu_q(alu_q), .alu_f(alu_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Z80 8-bit ALU behaviour for ADD/ADC/SUB/SBC and flag pass-through.
  function automatic logic [15:0] alu8(input logic [3:0] aop, input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] fi, input logic ar16, input logic z16);
    logic sub;
    int cin, ua, ub, r, hr, sr;
    logic [7:0] q, f;
    logic c, h, ov;
    if (aop == 4'hF) return {fi, a};
    sub = aop[1];
    cin = aop[0] ? int'(fi[0]) : 0;
    ua  = int'(a);
    ub  = int'(b);
    if (sub) begin
      r  = ua - ub - cin;
      hr = (ua & 15) - (ub & 15) - cin;
      sr = int'($signed(a)) - int'($signed(b)) - cin;
      c  = (r < 0);
      h  = (hr < 0);
    end else begin
      r  = ua + ub + cin;
      hr = (ua & 15) + (ub & 15) + cin;
      sr = int'($signed(a)) + int'($signed(b)) + cin;
      c  = (r > 255);
      h  = (hr > 15);
    end
    q  = r[7:0];
    ov = (sr > 127) || (sr < -128);
    f  = {q[7], (q == 8'h00) && (z16 ? fi[6] : 1'b1), q[5], h, q[3], ov, sub, c};
    if (ar16) begin
      f[7] = fi[7];
      f[6] = fi[6];
      f[2] = fi[2];
    end
    return {f, q};
  endfunction

  always_comb {alu_f, alu_q} = alu8(alu_op, alu_bus_a, alu_bus_b, alu_f_in, alu_arith16, alu_z16);

  // Whole 16-bit operation as plain arithmetic: returns {flags, result}.
  function automatic logic [23:0] ref16(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                        input logic [7:0] fi);
    logic sub;
    int cin, ua, ub, r, sr;
    logic [15:0] res;
    logic [7:0] f;
    logic c, h, ov;
    sub = o[1];
    cin = (o == 2'b01 || o == 2'b10) ? int'(fi[0]) : 0;
    ua  = int'(a);
    ub  = int'(b);
    if (sub) begin
      r  = ua - ub - cin;
      sr = int'($signed(a)) - int'($signed(b)) - cin;
      c  = (ua < ub + cin);
      h  = ((ua & 'hFFF) < (ub & 'hFFF) + cin);
    end else begin
      r  = ua + ub + cin;
      sr = int'($signed(a)) + int'($signed(b)) + cin;
      c  = (r > 65535);
      h  = ((ua & 'hFFF) + (ub & 'hFFF) + cin > 'hFFF);
    end
    res = r[15:0];
    ov  = (sr > 32767) || (sr < -32768);
    f   = {res[15], res == 16'h0000, res[13], h, res[11], ov, sub, c};
    if (o == 2'b00) begin
      f[7] = fi[7];
      f[6] = fi[6];
      f[2] = fi[2];
    end
    return {f, res};
  endfunction

  // Reference timeline: age = edges since the accepting edge (100 = idle).
  int          age = 100;
  logic [23:0] m_ref;
  logic [15:0] m_res, m_a, m_b;
  logic [7:0]  m_f, m_fi;
  logic [1:0]  m_op;
  logic [3:0]  lo_code [4];
  initial begin
    lo_code[0] = 4'h0;
    lo_code[1] = 4'h1;
    lo_code[2] = 4'h3;
    lo_code[3] = 4'h2;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      age   <= 100;
      m_res <= 16'h0000;
      m_f   <= 8'h00;
    end else begin
      if (age >= 3 && start) begin
        age   <= 0;
        m_ref <= ref16(op, opa, opb, f_in);
        m_op  <= op;
        m_a   <= opa;
        m_b   <= opb;
        m_fi  <= f_in;
      end else if (age < 100) begin
        age <= age + 1;
      end
      if (age == 0) m_res[7:0] <= m_ref[7:0];
      if (age == 1) begin
        m_res <= m_ref[15:0];
        m_f   <= m_ref[23:16];
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("busy", 32'(busy), 32'(age <= 2));
      check("done", 32'(done), 32'(age == 2));
      check("result", 32'(result), 32'(m_res));
      check("f_out", 32'(f_out), 32'(m_f));
      if (age >= 2)
        check("alu_idle", {2'b0, alu_op, alu_bus_a, alu_bus_b, alu_f_in, alu_arith16, alu_z16},
              {2'b0, 4'hF, 24'h0, 2'b00});
      else if (age == 0)
        check("alu_lo", {2'b0, alu_op, alu_bus_a, alu_bus_b, alu_f_in, alu_arith16, alu_z16},
              {2'b0, lo_code[m_op], m_a[7:0], m_b[7:0], m_fi, m_op == 2'b00, 1'b0});
      else
        check("alu_hi", {10'b0, alu_op, alu_bus_a, alu_bus_b, alu_arith16, alu_z16},
              {10'b0, (m_op[1] ? 4'h3 : 4'h1), m_a[15:8], m_b[15:8], m_op == 2'b00, m_op != 2'b00});
    end
  end

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic scramble();
    op   = 2'($urandom);
    opa  = pick16();
    opb  = pick16();
    f_in = 8'($urandom);
  endtask

  // Directed operation with literal expectations; inputs scrambled once accepted.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] f, input logic [15:0] er, input logic [7:0] ef);
    int k;
    check({nm, "_model"}, 32'(ref16(o, a, b, f)), {8'h0, ef, er});
    start = 1'b1; op = o; opa = a; opb = b; f_in = f;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    k = 0;
    while (!done && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check({nm, "_latency"}, 32'(k), 32'd2);
    check({nm, "_result"}, 32'(result), 32'(er));
    check({nm, "_f_out"}, 32'(f_out), 32'(ef));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int dones, first, last;
    reset = 1'b1; start = 1'b0; op = 2'b00; opa = 16'h0; opb = 16'h0; f_in = 8'h0;
    #12;
    check("rst_state", {busy, done, 6'b0, result, f_out}, 32'h0);
    check("rst_alu", {2'b0, alu_op, alu_bus_a, alu_bus_b, alu_f_in, alu_arith16, alu_z16},
          {2'b0, 4'hF, 24'h0, 2'b00});
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("add16", 2'b00, 16'h7FFF, 16'h0001, 8'h00, 16'h8000, 8'h10);
    run_op("adc16", 2'b01, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51);
    run_op("sbc16", 2'b10, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h3E);
    run_op("adc_z", 2'b01, 16'h0100, 16'h0000, 8'h00, 16'h0100, 8'h00);
    run_op("sub_z", 2'b11, 16'h1234, 16'h1234, 8'h00, 16'h0000, 8'h42);

    // start held for 8 edges: exactly two operations, four cycles apart
    dones = 0; first = -1; last = -1;
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 7) start = 1'b0;
      scramble();
      if (done) begin
        dones++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("held_start_ops", 32'(dones), 32'd2);
    check("held_start_spacing", 32'(last - first), 32'd4);

    // reset while in HI: clears immediately, no done afterwards
    start = 1'b1; op = 2'b00; opa = 16'h1111; opb = 16'h2222; f_in = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("hi_rst_state", {busy, done, 6'b0, result, f_out}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("hi_rst_no_done", 32'(dones), 32'd0);
    run_op("after_rst", 2'b11, 16'h1234, 16'h1234, 8'hFF, 16'h0000, 8'h42);

    // randomized traffic; the per-cycle compare checks against the model
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      scramble();
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #3;
        reset = 1'b0;
      end
    end
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
